lc3_addr_seq: RTL and testbench

LC3_ADDR_SEQ -- requirements
Module: lc3_addr_seq

---
 rtl/lc3_addr_seq.sv | 166 ++++++++++++++++
 tb/tb_lc3_addr_seq.sv | 111 +++++++++++
 2 files changed

// File: rtl/lc3_addr_seq.sv
// lc3_addr_seq: LC-3 address-phase sequencer driving address muxes, gates, loads and memory strobes
module lc3_addr_seq #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Start,
  input  logic [3:0] i_Opcode,
  input  logic       i_IR_11,
  input  logic       i_BEN,
  input  logic       i_MemReady,
  output logic       o_Addr1MuxControl,
  output logic [1:0] o_Addr2MuxControl,
  output logic       o_GateMARMUX,
  output logic       o_GateMDR,
  output logic       o_GateSR,
  output logic       o_LD_MAR,
  output logic       o_LD_MDR,
  output logic       o_LD_PC,
  output logic       o_LD_REG,
  output logic       o_LD_R7,
  output logic       o_LD_CC,
  output logic       o_MIO_En,
  output logic       o_MemWE,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Fault
);
  typedef enum logic [2:0] {IDLE, CALC, MEM_RD, INDIR, ST_MDR, MEM_WR, WB, DONE} state_t;
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic       ir11_q, ir11_d, ind_q, ind_d, fault_q, fault_d;
  logic [7:0] cnt_q, cnt_d;
  logic       is_br, is_jmp, is_jsr, is_lea, is_pcrel, is_basereg, is_ind, is_rd, is_st, timeout;
  assign is_br      = op_q == 4'b0000;
  assign is_jmp     = op_q == 4'b1100;
  assign is_jsr     = op_q == 4'b0100;
  assign is_lea     = op_q == 4'b1110;
  assign is_pcrel   = op_q == 4'b0010 || op_q == 4'b0011 || op_q == 4'b1010 || op_q == 4'b1011;
  assign is_basereg = op_q == 4'b0110 || op_q == 4'b0111;
  assign is_ind     = op_q == 4'b1010 || op_q == 4'b1011;
  assign is_rd      = op_q == 4'b0010 || op_q == 4'b0110 || is_ind;
  assign is_st      = op_q == 4'b0011 || op_q == 4'b0111;
  assign timeout    = !i_MemReady && cnt_q == TIMEOUT;
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      ir11_q  <= 1'b0;
      ind_q   <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ir11_q  <= ir11_d;
      ind_q   <= ind_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ir11_d  = ir11_q;
    ind_d   = ind_q;
    fault_d = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        op_d    = i_Start ? i_Opcode : op_q;
        ir11_d  = i_Start ? i_IR_11 : ir11_q;
        state_d = i_Start ? CALC : IDLE;
      end
      CALC: begin
        ind_d   = is_ind;
        cnt_d   = '0;
        state_d = is_rd ? MEM_RD : is_st ? ST_MDR : DONE;
      end
      MEM_RD: begin
        state_d = i_MemReady ? (ind_q ? INDIR : WB) : timeout ? DONE : MEM_RD;
        fault_d = timeout;
        cnt_d   = i_MemReady || timeout ? cnt_q : cnt_q + 8'd1;
      end
      INDIR: begin
        ind_d   = 1'b0;
        cnt_d   = '0;
        state_d = op_q == 4'b1010 ? MEM_RD : ST_MDR;
      end
      ST_MDR: begin
        cnt_d   = '0;
        state_d = MEM_WR;
      end
      MEM_WR: begin
        state_d = i_MemReady || timeout ? DONE : MEM_WR;
        fault_d = timeout;
        cnt_d   = i_MemReady || timeout ? cnt_q : cnt_q + 8'd1;
      end
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are forced low while reset is asserted, not just after it takes effect.
  always_comb begin
    o_Addr1MuxControl = 1'b0;
    o_Addr2MuxControl = 2'b00;
    o_GateMARMUX      = 1'b0;
    o_GateMDR         = 1'b0;
    o_GateSR          = 1'b0;
    o_LD_MAR          = 1'b0;
    o_LD_MDR          = 1'b0;
    o_LD_PC           = 1'b0;
    o_LD_REG          = 1'b0;
    o_LD_R7           = 1'b0;
    o_LD_CC           = 1'b0;
    o_MIO_En          = 1'b0;
    o_MemWE           = 1'b0;
    o_Busy            = 1'b0;
    o_Done            = 1'b0;
    o_Fault           = 1'b0;
    if (!i_Reset) begin
      o_Busy = state_q != IDLE;
      case (state_q)
        CALC: begin
          o_Addr1MuxControl = is_jmp || is_basereg || (is_jsr && !ir11_q);
          o_Addr2MuxControl = is_br || is_lea || is_pcrel ? 2'b10 :
                              is_basereg ? 2'b01 : is_jsr && ir11_q ? 2'b11 : 2'b00;
          o_GateMARMUX      = is_lea || is_pcrel || is_basereg;
          o_LD_MAR          = is_pcrel || is_basereg;
          o_LD_PC           = is_jmp || is_jsr || (is_br && i_BEN);
          o_LD_R7           = is_jsr;
          o_LD_REG          = is_lea;
          o_LD_CC           = is_lea;
        end
        MEM_RD: begin
          o_MIO_En = 1'b1;
          o_LD_MDR = 1'b1;
        end
        INDIR: begin
          o_GateMDR = 1'b1;
          o_LD_MAR  = 1'b1;
        end
        ST_MDR: begin
          o_GateSR = 1'b1;
          o_LD_MDR = 1'b1;
        end
        MEM_WR: begin
          o_MIO_En = 1'b1;
          o_MemWE  = 1'b1;
        end
        WB: begin
          o_GateMDR = 1'b1;
          o_LD_REG  = 1'b1;
          o_LD_CC   = 1'b1;
        end
        DONE: begin
          o_Done  = 1'b1;
          o_Fault = fault_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lc3_addr_seq.sv
// tb_lc3_addr_seq: directed-step bench with a queue of expected per-cycle output vectors
module tb_lc3_addr_seq;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, ir11 = 1'b0, ben = 1'b0, rdy = 1'b0;
  logic [3:0] op = '0;
  logic a1, gm, gmdr, gsr, lmar, lmdr, lpc, lreg, lr7, lcc, mio, we, busy, done, fault;
  logic [1:0] a2;
  logic [16:0] exp_q[$];
  int n_cmp = 0, n_err = 0;

  localparam logic [16:0] A1 = 17'h10000, A2_OFF6 = 17'h04000, A2_PC9 = 17'h08000, A2_PC11 = 17'h0C000;
  localparam logic [16:0] GM = 17'h02000, GMDR = 17'h01000, GSR = 17'h00800, LMAR = 17'h00400;
  localparam logic [16:0] LMDR = 17'h00200, LPC = 17'h00100, LREG = 17'h00080, LR7 = 17'h00040;
  localparam logic [16:0] LCC = 17'h00020, MIO = 17'h00010, WE = 17'h00008, B = 17'h00004;
  localparam logic [16:0] DN = 17'h00002, FLT = 17'h00001, Z = 17'h00000;

  lc3_addr_seq #(.MEM_TIMEOUT(4)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Opcode(op), .i_IR_11(ir11), .i_BEN(ben),
    .i_MemReady(rdy), .o_Addr1MuxControl(a1), .o_Addr2MuxControl(a2), .o_GateMARMUX(gm),
    .o_GateMDR(gmdr), .o_GateSR(gsr), .o_LD_MAR(lmar), .o_LD_MDR(lmdr), .o_LD_PC(lpc),
    .o_LD_REG(lreg), .o_LD_R7(lr7), .o_LD_CC(lcc), .o_MIO_En(mio), .o_MemWE(we),
    .o_Busy(busy), .o_Done(done), .o_Fault(fault));

  always #5 clk = ~clk;

  task automatic step(input logic s, input logic [3:0] o, input logic i, input logic b,
                      input logic r, input logic rs, input logic [16:0] e, input string tag);
    logic [16:0] got, want;
    @(negedge clk);
    start = s; op = o; ir11 = i; ben = b; rdy = r; rst = rs;
    exp_q.push_back(e);
    #1;
    got = {a1, a2, gm, gmdr, gsr, lmar, lmdr, lpc, lreg, lr7, lcc, mio, we, busy, done, fault};
    want = exp_q.pop_front();
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s observed=%05h expected=%05h", tag, got, want);
    end
  endtask

  initial begin
    step(0, 4'h0, 0, 0, 0, 1, Z, "rst_hold");
    step(1, 4'hC, 0, 0, 0, 1, Z, "rst_start_ignored");
    step(0, 4'h0, 0, 0, 0, 0, Z, "post_rst_idle");
    step(1, 4'hE, 0, 0, 0, 0, Z, "lea_idle");
    step(0, 4'h0, 0, 0, 0, 0, B | A2_PC9 | GM | LREG | LCC, "lea_calc");
    step(1, 4'hC, 0, 0, 0, 0, B | DN, "lea_done_start_ignored");
    step(0, 4'h0, 0, 0, 0, 0, Z, "lea_idle_after");
    step(1, 4'h0, 0, 0, 0, 0, Z, "br0_idle");
    step(0, 4'h0, 0, 0, 0, 0, B | A2_PC9, "br0_calc");
    step(0, 4'h0, 0, 0, 0, 0, B | DN, "br0_done");
    step(1, 4'h0, 0, 0, 0, 0, Z, "br1_idle");
    step(0, 4'h0, 0, 1, 0, 0, B | A2_PC9 | LPC, "br1_calc");
    step(0, 4'h0, 0, 0, 0, 0, B | DN, "br1_done");
    step(1, 4'h4, 1, 0, 0, 0, Z, "jsr_idle");
    step(0, 4'h0, 0, 0, 0, 0, B | A2_PC11 | LR7 | LPC, "jsr_calc");
    step(0, 4'h0, 0, 0, 0, 0, B | DN, "jsr_done");
    step(1, 4'h4, 0, 0, 0, 0, Z, "jsrr_idle");
    step(0, 4'h0, 1, 0, 0, 0, B | A1 | LR7 | LPC, "jsrr_calc");
    step(0, 4'h0, 0, 0, 0, 0, B | DN, "jsrr_done");
    step(1, 4'hD, 0, 0, 0, 0, Z, "illegal_idle");
    step(0, 4'h0, 0, 0, 0, 0, B, "illegal_calc");
    step(0, 4'h0, 0, 0, 0, 0, B | DN, "illegal_done");
    step(1, 4'hA, 0, 0, 0, 0, Z, "ldi_idle");
    step(0, 4'h0, 0, 0, 0, 0, B | A2_PC9 | GM | LMAR, "ldi_calc");
    step(0, 4'h0, 0, 0, 0, 0, B | MIO | LMDR, "ldi_rd1_w0");
    step(0, 4'h0, 0, 0, 0, 0, B | MIO | LMDR, "ldi_rd1_w1");
    step(0, 4'h0, 0, 0, 1, 0, B | MIO | LMDR, "ldi_rd1_rdy");
    step(0, 4'h0, 0, 0, 0, 0, B | GMDR | LMAR, "ldi_indir");
    step(0, 4'h0, 0, 0, 0, 0, B | MIO | LMDR, "ldi_rd2_w0");
    step(0, 4'h0, 0, 0, 0, 0, B | MIO | LMDR, "ldi_rd2_w1");
    step(0, 4'h0, 0, 0, 1, 0, B | MIO | LMDR, "ldi_rd2_rdy");
    step(0, 4'h0, 0, 0, 0, 0, B | GMDR | LREG | LCC, "ldi_wb");
    step(0, 4'h0, 0, 0, 0, 0, B | DN, "ldi_done");
    step(1, 4'h7, 0, 0, 0, 0, Z, "str_idle");
    step(0, 4'h0, 0, 0, 0, 0, B | A1 | A2_OFF6 | GM | LMAR, "str_calc");
    step(0, 4'h0, 0, 0, 0, 0, B | GSR | LMDR, "str_st_mdr");
    step(0, 4'h0, 0, 0, 1, 0, B | MIO | WE, "str_mem_wr");
    step(0, 4'h0, 0, 0, 0, 0, B | DN, "str_done");
    step(0, 4'h0, 0, 0, 0, 0, Z, "str_idle_after");
    step(1, 4'h2, 0, 0, 0, 0, Z, "ldto_idle");
    step(0, 4'h0, 0, 0, 0, 0, B | A2_PC9 | GM | LMAR, "ldto_calc");
    for (int k = 0; k < 5; k++) step(0, 4'h0, 0, 0, 0, 0, B | MIO | LMDR, "ldto_wait");
    step(0, 4'h0, 0, 0, 0, 0, B | DN | FLT, "ldto_done_fault");
    step(0, 4'h0, 0, 0, 0, 0, Z, "ldto_fault_cleared");
    step(1, 4'h6, 0, 0, 0, 0, Z, "ldr_edge_idle");
    step(0, 4'h0, 0, 0, 0, 0, B | A1 | A2_OFF6 | GM | LMAR, "ldr_edge_calc");
    for (int k = 0; k < 4; k++) step(0, 4'h0, 0, 0, 0, 0, B | MIO | LMDR, "ldr_edge_wait");
    step(0, 4'h0, 0, 0, 1, 0, B | MIO | LMDR, "ldr_edge_rdy_at_limit");
    step(0, 4'h0, 0, 0, 0, 0, B | GMDR | LREG | LCC, "ldr_edge_wb");
    step(0, 4'h0, 0, 0, 0, 0, B | DN, "ldr_edge_done_nofault");
    step(1, 4'hB, 0, 0, 0, 0, Z, "sti_idle");
    step(0, 4'h0, 0, 0, 0, 0, B | A2_PC9 | GM | LMAR, "sti_calc");
    step(0, 4'h0, 0, 0, 1, 0, B | MIO | LMDR, "sti_rd");
    step(0, 4'h0, 0, 0, 0, 0, B | GMDR | LMAR, "sti_indir");
    step(0, 4'h0, 0, 0, 0, 0, B | GSR | LMDR, "sti_st_mdr");
    step(0, 4'h0, 0, 0, 0, 0, B | MIO | WE, "sti_wr_w0");
    step(0, 4'h0, 0, 0, 1, 0, B | MIO | WE, "sti_wr_rdy");
    step(0, 4'h0, 0, 0, 0, 0, B | DN, "sti_done");
    step(1, 4'h3, 0, 0, 0, 0, Z, "st_idle");
    step(0, 4'h0, 0, 0, 0, 0, B | A2_PC9 | GM | LMAR, "st_calc");
    step(0, 4'h0, 0, 0, 0, 0, B | GSR | LMDR, "st_st_mdr");
    step(0, 4'h0, 0, 0, 0, 1, Z, "st_rst_in_mem_wr");
    step(1, 4'hC, 0, 0, 0, 0, Z, "post_rst_jmp_idle");
    step(0, 4'h0, 0, 0, 0, 0, B | A1 | LPC, "jmp_calc");
    step(0, 4'h0, 0, 0, 0, 0, B | DN, "jmp_done");
    step(0, 4'h0, 0, 0, 0, 0, Z, "jmp_idle_after");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
